// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_pkg
//  Brief    : Shared constants, operand bundle type and helpers for the
//             register-file access controller.
//  Revision : 1.0
// ============================================================================
package rf_pkg;

    localparam int DW   = 16;   // data width
    localparam int AW   = 4;    // register address width
    localparam int NREG = 13;   // implemented registers 0..NREG-1

    localparam logic [DW-1:0] RF_ZERO = '0;

    // Registered bundle handed to execute
    typedef struct packed {
        logic [DW-1:0] op_a;
        logic [DW-1:0] op_b;
        logic [AW-1:0] op_dst;
        logic          op_dst_en;
    } opnd_t;

    // True when the address maps onto a physically implemented register
    function automatic logic reg_impl(input logic [AW-1:0] addr);
        return (addr < AW'(NREG));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : rf_scoreboard
//  Brief    : Pending-write tracking for the implemented registers. Issue
//             sets a bit, writeback clears it (set wins on the same edge).
//             Flags a sticky error on a writeback with nothing pending.
//  Revision : 1.0
// ============================================================================
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] q_src0,
    input  logic [AW-1:0] q_src1,
    input  logic [AW-1:0] q_dst,
    output logic          pend_src0,
    output logic          pend_src1,
    output logic          pend_dst,
    output logic          sb_err
);

    logic [NREG-1:0] pending;
    logic            pend_clr;
    logic            stray_wb;

    // Unimplemented addresses never match any entry and read back as clear
    function automatic logic lookup(input logic [NREG-1:0] vec, input logic [AW-1:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (addr == AW'(i)) begin
                hit = vec[i];
            end
        end
        return hit;
    endfunction

    // Query ports and stray-writeback detection
    always_comb begin
        pend_src0 = lookup(pending, q_src0);
        pend_src1 = lookup(pending, q_src1);
        pend_dst  = lookup(pending, q_dst);
        pend_clr  = lookup(pending, clr_addr);
        stray_wb  = clr_en && reg_impl(clr_addr) && !pend_clr;
    end

    // Pending vector: a newer writer issued on the same edge as a writeback keeps the bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (set_en && (set_addr == AW'(i))) begin
                    pending[i] <= 1'b1;
                end else if (clr_en && (clr_addr == AW'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky error, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_err <= 1'b0;
        end else if (stray_wb) begin
            sb_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rf_access_ctrl
//  Brief    : Initiator side of the 16x13 register file. Drives both read
//             ports and the write port, stalls on RAW/WAW hazards, bypasses
//             same-cycle writeback data and registers operands for execute.
//  Revision : 1.0
// ============================================================================
module rf_access_ctrl
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_valid,
    output logic          iss_ready,
    input  logic [AW-1:0] iss_src0,
    input  logic [AW-1:0] iss_src1,
    input  logic [AW-1:0] iss_dst,
    input  logic          iss_dst_en,
    output logic [AW-1:0] rf_rd_addr_0,
    output logic [AW-1:0] rf_rd_addr_1,
    input  logic [DW-1:0] rf_rd_data_0,
    input  logic [DW-1:0] rf_rd_data_1,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [AW-1:0] op_dst,
    output logic          op_dst_en,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_wr_data,
    output logic          sb_err
);

    logic  pend_src0;
    logic  pend_src1;
    logic  pend_dst;
    logic  src0_haz;
    logic  src1_haz;
    logic  waw_haz;
    logic  accept;
    logic  set_en;
    opnd_t op_next;
    opnd_t op_q;

    // Unimplemented sources read as zero so a floating read bus never reaches execute
    function automatic logic [DW-1:0] sel_opnd(
        input logic [AW-1:0] src,
        input logic [DW-1:0] rd_data
    );
        if (!reg_impl(src)) begin
            return RF_ZERO;
        end else if (wb_valid && (wb_addr == src)) begin
            return wb_data;
        end else begin
            return rd_data;
        end
    endfunction

    assign rf_rd_addr_0 = iss_src0;
    assign rf_rd_addr_1 = iss_src1;
    assign rf_wr_en     = wb_valid && rst_n && reg_impl(wb_addr);
    assign rf_wr_addr   = wb_addr;
    assign rf_wr_data   = wb_data;

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (set_en),
        .set_addr  (iss_dst),
        .clr_en    (wb_valid),
        .clr_addr  (wb_addr),
        .q_src0    (iss_src0),
        .q_src1    (iss_src1),
        .q_dst     (iss_dst),
        .pend_src0 (pend_src0),
        .pend_src1 (pend_src1),
        .pend_dst  (pend_dst),
        .sb_err    (sb_err)
    );

    // Hazards resolved by a same-cycle writeback do not stall; ready ignores iss_valid
    always_comb begin
        src0_haz  = reg_impl(iss_src0) && pend_src0 && !(wb_valid && (wb_addr == iss_src0));
        src1_haz  = reg_impl(iss_src1) && pend_src1 && !(wb_valid && (wb_addr == iss_src1));
        waw_haz   = iss_dst_en && reg_impl(iss_dst) && pend_dst && !(wb_valid && (wb_addr == iss_dst));
        iss_ready = !src0_haz && !src1_haz && !waw_haz && (!op_valid || op_ready);
        accept    = iss_valid && iss_ready;
        set_en    = accept && iss_dst_en && reg_impl(iss_dst);

        op_next.op_a      = sel_opnd(iss_src0, rf_rd_data_0);
        op_next.op_b      = sel_opnd(iss_src1, rf_rd_data_1);
        op_next.op_dst    = iss_dst;
        op_next.op_dst_en = iss_dst_en;
    end

    // Output stage: load on accept, hold while stalled by execute, drop valid once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_q     <= '0;
        end else if (accept) begin
            op_valid <= 1'b1;
            op_q     <= op_next;
        end else if (op_ready) begin
            op_valid <= 1'b0;
        end
    end

    assign op_a      = op_q.op_a;
    assign op_b      = op_q.op_b;
    assign op_dst    = op_q.op_dst;
    assign op_dst_en = op_q.op_dst_en;

endmodule
`default_nettype wire
